// File: rtl/exec_unit_if.sv
// exec_unit_if: issue/forward bundle between the reservation station side and
// the execution stage.
//   inOperation      [41:38] opcode, [37:32] ROB tag, [31:16] A, [15:0] B
//   inOperationValid issue strobe, no backpressure
//   flush            synchronous squash of all in-flight work
//   forwardAlu/Mul   [22] valid, [21:16] ROB tag, [15:0] result
//   opCount          accepted-operation counter (wraps)
// master = issuing side, slave = exec_unit.
interface exec_unit_if;
  logic [41:0] inOperation;
  logic        inOperationValid;
  logic        flush;
  logic [22:0] forwardAlu;
  logic [22:0] forwardMul;
  logic [15:0] opCount;

  modport master (
    output inOperation, inOperationValid, flush,
    input  forwardAlu, forwardMul, opCount
  );

  modport slave (
    input  inOperation, inOperationValid, flush,
    output forwardAlu, forwardMul, opCount
  );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: execution stage behind the reservation station.
//   clk, rst_n   clock, async active-low reset
//   io (slave)   issue operation in, two forwarding buses + opCount out
// One op per cycle is accepted (valid & !flush). Opcodes 11..13 go to a
// 3-stage multiplier (S1 operands, S2 product, S3 selected half), all others
// to a 1-cycle ALU output register. Both buses can be valid together.
module exec_unit (
  input  logic         clk,
  input  logic         rst_n,
  exec_unit_if.slave   io
);
  localparam int MUL_STAGES = 3;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MOVB  = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULH  = 4'd12;
  localparam logic [3:0] OP_MULHU = 4'd13;

  typedef struct packed {
    logic [3:0]  op;
    logic [5:0]  tag;
    logic [15:0] a;
    logic [15:0] b;
  } issue_t;

  issue_t iss;
  logic   acc, is_mul, mul_acc, alu_acc;
  assign iss     = issue_t'(io.inOperation);
  assign acc     = io.inOperationValid & ~io.flush;
  assign is_mul  = (iss.op == OP_MUL) | (iss.op == OP_MULH) | (iss.op == OP_MULHU);
  assign mul_acc = acc & is_mul;
  assign alu_acc = acc & ~is_mul;

  // ---------------- ALU ----------------
  logic [15:0] alu_nxt;
  always_comb begin
    alu_nxt = '0;
    case (iss.op)
      OP_ADD:  alu_nxt = iss.a + iss.b;
      OP_SUB:  alu_nxt = iss.a - iss.b;
      OP_AND:  alu_nxt = iss.a & iss.b;
      OP_OR:   alu_nxt = iss.a | iss.b;
      OP_XOR:  alu_nxt = iss.a ^ iss.b;
      OP_SLL:  alu_nxt = iss.a << iss.b[3:0];
      OP_SRL:  alu_nxt = iss.a >> iss.b[3:0];
      OP_SRA:  alu_nxt = 16'($signed(iss.a) >>> iss.b[3:0]);
      OP_SLT:  alu_nxt = {15'b0, $signed(iss.a) < $signed(iss.b)};
      OP_SLTU: alu_nxt = {15'b0, iss.a < iss.b};
      OP_MOVB: alu_nxt = iss.b;
      default: alu_nxt = '0;  // reserved 14/15 (and MUL ops, never loaded here)
    endcase
  end

  logic        alu_vld;
  logic [5:0]  alu_tag;
  logic [15:0] alu_res;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_vld <= 1'b0;
      alu_tag <= '0;
      alu_res <= '0;
    end else begin
      alu_vld <= alu_acc;
      if (alu_acc) begin
        alu_tag <= iss.tag;
        alu_res <= alu_nxt;
      end
    end
  end

  // ---------------- multiplier ----------------
  // vld_pipe[k] is the valid of stage Sk; flush empties every stage.
  logic [MUL_STAGES:1] vld_pipe;
  logic [3:0]  s1_op, s2_op;
  logic [5:0]  s1_tag, s2_tag, s3_tag;
  logic [15:0] s1_a, s1_b, s3_res;
  logic [31:0] s2_prod;

  // Sign-extend only for MULH; the low 32 bits of the product of the
  // extended operands is then the correct product for every opcode.
  logic        s1_sgn;
  logic [31:0] a_ext, b_ext;
  assign s1_sgn = (s1_op == OP_MULH);
  assign a_ext  = {{16{s1_sgn & s1_a[15]}}, s1_a};
  assign b_ext  = {{16{s1_sgn & s1_b[15]}}, s1_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_op    <= '0;
      s2_tag   <= '0;
      s2_prod  <= '0;
      s3_tag   <= '0;
      s3_res   <= '0;
    end else begin
      vld_pipe <= io.flush ? '0 : {vld_pipe[MUL_STAGES-1:1], mul_acc};
      if (mul_acc) begin
        s1_op  <= iss.op;
        s1_tag <= iss.tag;
        s1_a   <= iss.a;
        s1_b   <= iss.b;
      end
      if (vld_pipe[1]) begin
        s2_op   <= s1_op;
        s2_tag  <= s1_tag;
        s2_prod <= a_ext * b_ext;
      end
      if (vld_pipe[2]) begin
        s3_tag <= s2_tag;
        s3_res <= (s2_op == OP_MUL) ? s2_prod[15:0] : s2_prod[31:16];
      end
    end
  end

  // ---------------- op counter ----------------
  logic [15:0] op_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_cnt <= '0;
    else if (acc) op_cnt <= op_cnt + 16'd1;
  end

  assign io.forwardAlu = {alu_vld, alu_tag, alu_res};
  assign io.forwardMul = {vld_pipe[MUL_STAGES], s3_tag, s3_res};
  assign io.opCount    = op_cnt;
endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_unit_if io ();
  exec_unit dut (.clk(clk), .rst_n(rst_n), .io(io));

  int n_chk = 0;
  int n_fail = 0;

  // Reference: expected bus contents indexed by the edge after which they show.
  logic [22:0] exp_alu [DEPTH];
  logic [22:0] exp_mul [DEPTH];
  logic [15:0] exp_cnt;
  int          edge_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_res(input int op, input int a, input int b);
    int sa, sb, sh;
    longint p;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    sh = b % 16;
    case (op)
      0:  return 16'(a + b);
      1:  return 16'(a - b);
      2:  return 16'(a & b);
      3:  return 16'(a | b);
      4:  return 16'(a ^ b);
      5:  return 16'(a << sh);
      6:  return 16'(a >> sh);
      7:  return 16'(sa >>> sh);
      8:  return (sa < sb) ? 16'd1 : 16'd0;
      9:  return (a < b) ? 16'd1 : 16'd0;
      10: return 16'(b);
      11: begin p = longint'(a) * longint'(b); return 16'(p); end
      12: begin p = longint'(sa) * longint'(sb); return 16'(p >>> 16); end
      13: begin p = longint'(a) * longint'(b); return 16'(p >> 16); end
      default: return 16'h0000;
    endcase
  endfunction

  task automatic clear_model();
    for (int k = 0; k < DEPTH; k++) begin
      exp_alu[k] = '0;
      exp_mul[k] = '0;
    end
    exp_cnt = '0;
  endtask

  // Called at a negedge: drive one cycle, update model, clock, check at next negedge.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [5:0] tag,
                       input logic [15:0] a, input logic [15:0] b, input logic fl);
    int e;
    logic [15:0] r;
    io.inOperation      = {op, tag, a, b};
    io.inOperationValid = v;
    io.flush            = fl;
    e = edge_cnt + 1;
    if (fl)
      for (int k = e; k < DEPTH; k++) begin
        exp_alu[k] = '0;
        exp_mul[k] = '0;
      end
    if (v && !fl) begin
      exp_cnt = exp_cnt + 16'd1;
      r = ref_res(int'(op), int'(a), int'(b));
      if (op >= 4'd11 && op <= 4'd13) exp_mul[e+2] = {1'b1, tag, r};
      else                            exp_alu[e]   = {1'b1, tag, r};
    end
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    if (exp_alu[edge_cnt][22]) chk("alu_bus", 32'(io.forwardAlu), 32'(exp_alu[edge_cnt]));
    else                       chk("alu_vld", 32'(io.forwardAlu[22]), 32'd0);
    if (exp_mul[edge_cnt][22]) chk("mul_bus", 32'(io.forwardMul), 32'(exp_mul[edge_cnt]));
    else                       chk("mul_vld", 32'(io.forwardMul[22]), 32'd0);
    chk("opcount", 32'(io.opCount), 32'(exp_cnt));
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 6'd0, 16'd0, 16'd0, 1'b0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] cnt0;
    io.inOperation = '0;
    io.inOperationValid = 1'b0;
    io.flush = 1'b0;
    clear_model();
    edge_cnt = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_alu", 32'(io.forwardAlu), 32'd0);
    chk("rst_mul", 32'(io.forwardMul), 32'd0);
    chk("rst_cnt", 32'(io.opCount), 32'd0);
    rst_n = 1'b1;

    // directed ALU
    cycle(1'b1, 4'd0, 6'd5, 16'h7FFF, 16'h0001, 1'b0);
    chk("add_lit", 32'(io.forwardAlu), 32'({1'b1, 6'd5, 16'h8000}));
    cycle(1'b1, 4'd1, 6'd6, 16'h0000, 16'h0001, 1'b0);
    chk("sub_lit", 32'(io.forwardAlu), 32'({1'b1, 6'd6, 16'hFFFF}));
    cycle(1'b1, 4'd7, 6'd4, 16'h8000, 16'h0004, 1'b0);
    chk("sra_lit", 32'(io.forwardAlu), 32'({1'b1, 6'd4, 16'hF800}));
    cycle(1'b1, 4'd8, 6'd2, 16'hFFFF, 16'h0001, 1'b0);
    chk("slt_lit", 32'(io.forwardAlu), 32'({1'b1, 6'd2, 16'h0001}));
    idle();

    // MUL stream
    cycle(1'b1, 4'd11, 6'd1, 16'h0100, 16'h0100, 1'b0);
    cycle(1'b1, 4'd12, 6'd2, 16'hFFFF, 16'h0002, 1'b0);
    cycle(1'b1, 4'd13, 6'd3, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("mul_lit", 32'(io.forwardMul), 32'({1'b1, 6'd1, 16'h0000}));
    idle();
    chk("mulh_lit", 32'(io.forwardMul), 32'({1'b1, 6'd2, 16'hFFFF}));
    idle();
    chk("mulhu_lit", 32'(io.forwardMul), 32'({1'b1, 6'd3, 16'hFFFE}));
    repeat (2) idle();

    // simultaneous buses
    cycle(1'b1, 4'd11, 6'd7, 16'd3, 16'd5, 1'b0);
    idle();
    cycle(1'b1, 4'd0, 6'd8, 16'd1, 16'd2, 1'b0);
    chk("sim_mul", 32'(io.forwardMul), 32'({1'b1, 6'd7, 16'd15}));
    chk("sim_alu", 32'(io.forwardAlu), 32'({1'b1, 6'd8, 16'd3}));
    repeat (2) idle();

    // flush kills in-flight MUL and the presented ADD
    cnt0 = exp_cnt;
    cycle(1'b1, 4'd11, 6'd9, 16'd2, 16'd3, 1'b0);
    idle();
    cycle(1'b1, 4'd0, 6'd10, 16'd1, 16'd1, 1'b1);
    chk("flush_alu", 32'(io.forwardAlu[22]), 32'd0);
    repeat (3) idle();
    chk("flush_cnt", 32'(io.opCount), 32'(cnt0 + 16'd1));

    // reserved opcode
    cycle(1'b1, 4'd15, 6'd3, 16'h1234, 16'h5678, 1'b0);
    chk("rsv_lit", 32'(io.forwardAlu), 32'({1'b1, 6'd3, 16'h0000}));
    idle();

    // counter wrap
    force dut.op_cnt = 16'hFFFE;
    #1 release dut.op_cnt;
    exp_cnt = 16'hFFFE;
    cycle(1'b1, 4'd2, 6'd11, 16'hF0F0, 16'h0FF0, 1'b0);
    cycle(1'b1, 4'd3, 6'd12, 16'hF0F0, 16'h0FF0, 1'b0);
    chk("wrap_lit", 32'(io.opCount), 32'd0);

    // randomized
    for (int i = 0; i < 300; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 9) < 8, rop, 6'($urandom), pick(), pick(),
            $urandom_range(0, 19) == 0);
    end
    repeat (3) idle();

    // async reset mid-MUL
    cycle(1'b1, 4'd11, 6'd20, 16'd7, 16'd9, 1'b0);
    cycle(1'b1, 4'd0, 6'd21, 16'd1, 16'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu", 32'(io.forwardAlu), 32'd0);
    chk("arst_mul", 32'(io.forwardMul), 32'd0);
    chk("arst_cnt", 32'(io.opCount), 32'd0);
    io.inOperationValid = 1'b0;
    clear_model();
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle();
    cycle(1'b1, 4'd4, 6'd22, 16'hAAAA, 16'hFFFF, 1'b0);
    chk("post_rst", 32'(io.forwardAlu), 32'({1'b1, 6'd22, 16'h5555}));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Execution stage downstream of the reservation station. Consumes one issued 42-bit operation per cycle and computes it in one of two pipelines: a single-cycle ALU and a 3-stage pipelined 16-bit multiplier. Results are broadcast on two 23-bit forwarding buses. These buses feed the reservation station's forward inputs and the ROB. There is no backpressure: an issued operation is always accepted.

## Interface
- No parameters. Widths are fixed by the issue and forward formats.
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of all in-flight work
- inOperation  input  42  [41:38] opcode, [37:32] ROB tag, [31:16] operand A, [15:0] operand B
- inOperationValid  input  1  inOperation is valid this cycle
- forwardAlu  output  23  [22] valid, [21:16] ROB tag, [15:0] result
- forwardMul  output  23  same format, multiplier results
- opCount  output  16  count of accepted (valid, not flushed) operations; wraps

## Operation
- Opcodes, ALU path:
  - 0 ADD A+B
  - 1 SUB A−B
  - 2 AND, 3 OR, 4 XOR
  - 5 SLL A<<B[3:0], 6 SRL, 7 SRA (arithmetic)
  - 8 SLT signed (1/0), 9 SLTU unsigned (1/0)
  - 10 MOVB (result = B)
  - 14, 15 reserved: result 16'h0000, still valid with its tag
- Opcodes, MUL path:
  - 11 MUL: low 16 bits of A×B
  - 12 MULH: high 16 bits of signed×signed
  - 13 MULHU: high 16 bits of unsigned×unsigned
- All add/sub/shift arithmetic is mod 2^16; no flags and no exceptions.
- Routing:
  - opcodes 11–13 enter the multiplier stage-1 register
  - all other opcodes enter the ALU output register
  - exactly one path is loaded per accepted operation
- Multiplier pipeline (each stage holds valid, tag, op, data):
  - S1: registered operands
  - S2: registered 32-bit product, sign handling per opcode
  - S3: registered selected half, driven on forwardMul
  - fully pipelined: a new MUL may enter every cycle
- Both buses may be valid in the same cycle with different tags. The downstream consumer handles both.
- flush:
  - clears the ALU output valid and all three multiplier stage valids at the edge
  - an inOperation presented in the flush cycle is discarded and not counted
  - opCount is not cleared by flush
- When a stage is invalid, its data and tag are don't-care. The bus value is still driven from the register, with [22]=0.
- Reset (rst_n=0, asynchronous): forwardAlu=0, forwardMul=0, opCount=0, all pipeline valids 0. Outputs are held at 0 while rst_n is low.

## Timing
- Accept: inOperationValid=1 and flush=0 at rising edge N.
- ALU latency 1: result valid on forwardAlu during the cycle after edge N. If no new ALU op arrives, [22] drops after one cycle.
- MUL latency 3: the op is loaded into S1 at edge N, advances to S2 at N+1 and S3 at N+2. Result is valid on forwardMul during the cycle after edge N+2.
- Each result is valid for exactly one cycle; there is no hold.
- Back-to-back MULs yield back-to-back valid results in issue order.
- opCount increments at edge N by 1 for each accepted op and wraps from 16'hFFFF to 0.
- Flush at edge F kills every result that would have appeared after F. Results already on the bus in the cycle containing F remain visible for that cycle.
- Reset release mid-stream: first acceptance on the first rising edge with rst_n=1.

## Test plan
- Reset then ALU ops:
  - ADD A=0x7FFF B=0x0001 tag 5 → forwardAlu = {1, 6'd5, 16'h8000} one cycle later
  - SUB 0x0000−0x0001 tag 6 → 16'hFFFF
  - SRA 0x8000 by 4 → 16'hF800
  - SLT 0xFFFF<0x0001 → 1
- MUL stream: MUL 0x0100×0x0100 (tag 1), MULH 0xFFFF×0x0002 (tag 2), MULHU 0xFFFF×0xFFFF (tag 3) on consecutive cycles → forwardMul shows:
  - 0x0000 / tag 1 three edges after the first issue
  - 0xFFFF / tag 2 the next cycle
  - 0xFFFE / tag 3 the cycle after
- Simultaneous buses: MUL tag 7 at cycle 0, ADD tag 8 at cycle 2 → both buses valid in the same cycle with the correct tags.
- Flush: issue MUL tag 9, then flush two cycles later together with a presented ADD → forwardMul never shows tag 9, the ADD never appears, opCount advances by 1 only.
- Wrap/reset: preload 0xFFFF accepted ops (or force the counter), accept one more → opCount=0. Assert rst_n low asynchronously mid-MUL → all outputs 0 immediately and no stale result after release.
- Reserved opcode 15 tag 3 → forwardAlu {1, 3, 0x0000}, forwardMul untouched.
